fetch_unit: RTL and testbench

//   Parametrised instruction-fetch front end; replaces the bare instruction-pointer + ROM

---
 rtl/fetch_unit.sv | 201 ++++++++++++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end. Holds the PC, issues reads to a synchronous
//   instruction memory with one cycle of read latency, buffers the returned
//   words together with their PC in a small FIFO and hands them to the core
//   over a valid/ready handshake. A redirect reloads the PC, empties the
//   buffer and discards any read still in flight.
//
// Ports
//   clk            clock, all state on the rising edge
//   rst_n          asynchronous active-low reset
//   redirect_valid load redirect_pc, flush buffer and in-flight fetch
//   redirect_pc    new fetch address
//   imem_req       read request to imem this cycle
//   imem_addr      read address (current PC)
//   imem_data      read data, valid the cycle after imem_req
//   inst_valid     buffer head holds a valid instruction
//   inst_ready     core accepts the head this cycle
//   inst_data      head instruction (0 when empty)
//   inst_pc        PC of head instruction (0 when empty)
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned        ADDR_W   = 8,
    parameter int unsigned        INST_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}},
    parameter logic [ADDR_W-1:0]  STEP     = {{(ADDR_W-1){1'b0}}, 1'b1},
    parameter int unsigned        DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] pc_r;
    logic              epoch_r;
    logic              inflight_r;
    logic [ADDR_W-1:0] tag_pc_r;
    logic              tag_epoch_r;

    logic [INST_W-1:0] buf_data_r [DEPTH];
    logic [ADDR_W-1:0] buf_pc_r   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic              pop_s;
    logic              push_s;
    logic              issue_s;
    logic [CNT_W:0]    need_s;
    logic              head_valid_s;

    // Circular pointer advance that also works for non power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Handshake, issue credit and push qualification.
    always_comb begin
        head_valid_s = 1'b0;
        pop_s        = 1'b0;
        need_s       = {(CNT_W + 1){1'b0}};
        issue_s      = 1'b0;
        push_s       = 1'b0;

        head_valid_s = (count_r != {CNT_W{1'b0}});
        pop_s        = head_valid_s & inst_ready;
        // Occupancy after this cycle's pop, counting the read already in flight.
        // Crediting the pop here is what allows one instruction per cycle.
        need_s = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r} - {{CNT_W{1'b0}}, pop_s};
        if (rst_n && !redirect_valid && (need_s < DEPTH_C)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        // A response is only kept if no redirect happened since it was issued.
        push_s = inflight_r & (tag_epoch_r == epoch_r) & ~redirect_valid;
    end

    // PC, epoch and in-flight tag tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r        <= RESET_PC;
            epoch_r     <= 1'b0;
            inflight_r  <= 1'b0;
            tag_pc_r    <= {ADDR_W{1'b0}};
            tag_epoch_r <= 1'b0;
        end else if (redirect_valid) begin
            pc_r       <= redirect_pc;
            epoch_r    <= ~epoch_r;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                pc_r        <= pc_r + STEP;
                tag_pc_r    <= pc_r;
                tag_epoch_r <= epoch_r;
            end
        end
    end

    // Instruction buffer: storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_data_r[i] <= {INST_W{1'b0}};
                buf_pc_r[i]   <= {ADDR_W{1'b0}};
            end
        end else if (redirect_valid) begin
            // A pop in this cycle has already been taken by the core; the
            // rest of the buffer is stale.
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                buf_data_r[wr_ptr_r] <= imem_data;
                buf_pc_r[wr_ptr_r]   <= tag_pc_r;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head presentation; forced to zero while the buffer is empty.
    always_comb begin
        inst_data = {INST_W{1'b0}};
        inst_pc   = {ADDR_W{1'b0}};
        if (head_valid_s) begin
            inst_data = buf_data_r[rd_ptr_r];
            inst_pc   = buf_pc_r[rd_ptr_r];
        end else begin
            inst_data = {INST_W{1'b0}};
            inst_pc   = {ADDR_W{1'b0}};
        end
    end

    assign inst_valid = head_valid_s;
    assign imem_req   = issue_s;
    assign imem_addr  = pc_r;

    fetch_unit_checker #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .count (count_r)
    );

endmodule

// ---------------------------------------------------------------------------
// fetch_unit_checker
//   Simulation-time property checks for fetch_unit.
//   clk, rst_n : as in fetch_unit
//   count      : buffer occupancy
// ---------------------------------------------------------------------------
module fetch_unit_checker #(
    parameter int unsigned CNT_W = 2,
    parameter int unsigned DEPTH = 2
) (
    input logic             clk,
    input logic             rst_n,
    input logic [CNT_W-1:0] count
);

    // The issue credit guarantees the buffer never overflows.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (count <= CNT_W'(DEPTH));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit: directed vector tables for the
//   documented cycle sequences, a second instance for PC wrap-around, an
//   asynchronous mid-stream reset, and a randomized phase compared against
//   a queue-based model of the fetch stream.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_data;
    logic [7:0]  inst_pc;

    logic        imem_req2;
    logic [7:0]  imem_addr2;
    logic [15:0] imem_data2;
    logic        inst_valid2;
    logic [15:0] inst_data2;
    logic [7:0]  inst_pc2;

    int total;
    int bad;

    fetch_unit #(.ADDR_W(8), .INST_W(16), .RESET_PC(8'h00), .STEP(8'h01), .DEPTH(DEPTH)) uut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    fetch_unit #(.ADDR_W(8), .INST_W(16), .RESET_PC(8'hFE), .STEP(8'h01), .DEPTH(DEPTH)) uut2 (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(1'b0), .redirect_pc(8'h00),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_data(imem_data2),
        .inst_valid(inst_valid2), .inst_ready(1'b1),
        .inst_data(inst_data2), .inst_pc(inst_pc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content: upper byte = address, lower byte = address ^ A5.
    function automatic logic [15:0] word(input logic [7:0] a);
        return {a, a ^ 8'hA5};
    endfunction

    always @(posedge clk) imem_data  <= word(imem_addr);
    always @(posedge clk) imem_data2 <= word(imem_addr2);

    // ---------------- reference model: stream of PCs ----------------
    logic [7:0] mq[$];       // buffered instruction PCs, head first
    logic       mpend;       // a read is outstanding
    logic [7:0] mpend_pc;
    logic [7:0] mpc;

    task automatic model_reset();
        mq.delete();
        mpend    = 1'b0;
        mpend_pc = 8'h00;
        mpc      = 8'h00;
    endtask

    typedef struct {
        logic        rv;
        logic [7:0]  rp;
        logic        rdy;
        logic        req;
        logic [7:0]  addr;
        logic        valid;
        logic [7:0]  pc;
        logic [15:0] data;
    } vec_t;

    function automatic vec_t mk(logic rv, logic [7:0] rp, logic rdy, logic req,
                                logic [7:0] addr, logic valid, logic [7:0] pc, logic [15:0] data);
        vec_t v;
        v.rv = rv; v.rp = rp; v.rdy = rdy; v.req = req;
        v.addr = addr; v.valid = valid; v.pc = pc; v.data = data;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One cycle: drive inputs, compare against model (and table row when asked),
    // then advance the model across the clock edge.
    task automatic step(input vec_t v, input bit use_tab, input string tag);
        logic       e_valid, e_req, pop;
        logic [7:0] e_pc;
        redirect_valid = v.rv;
        redirect_pc    = v.rp;
        inst_ready     = v.rdy;
        #1;
        e_valid = (mq.size() != 0);
        e_pc    = e_valid ? mq[0] : 8'h00;
        pop     = e_valid & v.rdy;
        e_req   = !v.rv && ((int'(mq.size()) + int'(mpend) - int'(pop)) < DEPTH);
        chk({tag, ".m_req"},   32'(imem_req),   32'(e_req));
        chk({tag, ".m_addr"},  32'(imem_addr),  32'(mpc));
        chk({tag, ".m_valid"}, 32'(inst_valid), 32'(e_valid));
        chk({tag, ".m_pc"},    32'(inst_pc),    32'(e_pc));
        chk({tag, ".m_data"},  32'(inst_data),  e_valid ? 32'(word(e_pc)) : 32'h0);
        if (use_tab) begin
            chk({tag, ".req"},   32'(imem_req),   32'(v.req));
            chk({tag, ".addr"},  32'(imem_addr),  32'(v.addr));
            chk({tag, ".valid"}, 32'(inst_valid), 32'(v.valid));
            chk({tag, ".pc"},    32'(inst_pc),    32'(v.pc));
            chk({tag, ".data"},  32'(inst_data),  32'(v.data));
        end
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (v.rv) begin
            mq.delete();
            mpend = 1'b0;
            mpc   = v.rp;
        end else begin
            if (mpend) mq.push_back(mpend_pc);
            mpend    = e_req;
            mpend_pc = mpc;
            if (e_req) mpc = mpc + 8'h01;
        end
        #1;
    endtask

    // Assert reset (asynchronously), check outputs at once, then release.
    task automatic reset_and_check(input string tag);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        inst_ready     = 1'b1;
        #1;
        chk({tag, ".req"},   32'(imem_req),   32'h0);
        chk({tag, ".addr"},  32'(imem_addr),  32'h0);
        chk({tag, ".valid"}, 32'(inst_valid), 32'h0);
        chk({tag, ".pc"},    32'(inst_pc),    32'h0);
        chk({tag, ".data"},  32'(inst_data),  32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    vec_t tA[$];
    vec_t tB[$];
    logic [7:0] exp2[4];

    initial begin
        total = 0;
        bad   = 0;

        // Stream from reset, redirect in steady state, redirect+pop with a
        // full buffer (to the current PC), back-to-back redirects.
        tA.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 16'h0000));
        tA.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 16'h0000));
        tA.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b1, 8'h00, 16'h00A5));
        tA.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b1, 8'h01, 16'h01A4));
        tA.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 1'b1, 8'h02, 16'h02A7));
        tA.push_back(mk(1'b1, 8'h40, 1'b1, 1'b0, 8'h05, 1'b1, 8'h03, 16'h03A6));
        tA.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 16'h0000));
        tA.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0, 8'h00, 16'h0000));
        tA.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h42, 1'b1, 8'h40, 16'h40E5));
        tA.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h43, 1'b1, 8'h41, 16'h41E4));
        tA.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h44, 1'b1, 8'h42, 16'h42E7));
        tA.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h44, 1'b1, 8'h42, 16'h42E7));
        tA.push_back(mk(1'b1, 8'h44, 1'b1, 1'b0, 8'h44, 1'b1, 8'h42, 16'h42E7));
        tA.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 1'b0, 8'h00, 16'h0000));
        tA.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h45, 1'b0, 8'h00, 16'h0000));
        tA.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h46, 1'b1, 8'h44, 16'h44E1));
        tA.push_back(mk(1'b1, 8'h80, 1'b1, 1'b0, 8'h47, 1'b1, 8'h45, 16'h45E0));
        tA.push_back(mk(1'b1, 8'h90, 1'b1, 1'b0, 8'h80, 1'b0, 8'h00, 16'h0000));
        tA.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h90, 1'b0, 8'h00, 16'h0000));
        tA.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h91, 1'b0, 8'h00, 16'h0000));
        tA.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h92, 1'b1, 8'h90, 16'h9035));

        // Back-pressure from reset, then release.
        tB.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 16'h0000));
        tB.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 16'h0000));
        tB.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 8'h00, 16'h00A5));
        tB.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 8'h00, 16'h00A5));
        tB.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 8'h00, 16'h00A5));
        tB.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b1, 8'h00, 16'h00A5));
        tB.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b1, 8'h01, 16'h01A4));
        tB.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 1'b1, 8'h02, 16'h02A7));
        tB.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 1'b1, 8'h03, 16'h03A6));

        exp2[0] = 8'hFE; exp2[1] = 8'hFF; exp2[2] = 8'h00; exp2[3] = 8'h01;

        reset_and_check("rst0");

        for (int i = 0; i < tA.size(); i++) begin
            // Second instance (RESET_PC=FE, always ready) shows the wrap.
            if (i == 0) chk("wrap.addr0", 32'(imem_addr2), 32'hFE);
            if (i >= 2 && i <= 5) begin
                chk($sformatf("wrap[%0d].valid", i), 32'(inst_valid2), 32'h1);
                chk($sformatf("wrap[%0d].pc", i),    32'(inst_pc2),    32'(exp2[i-2]));
                chk($sformatf("wrap[%0d].data", i),  32'(inst_data2),  32'(word(exp2[i-2])));
            end
            step(tA[i], 1'b1, $sformatf("tA[%0d]", i));
        end

        // Reset mid-stream with one entry buffered and one read in flight.
        reset_and_check("rst_mid");

        for (int i = 0; i < tB.size(); i++) begin
            step(tB[i], 1'b1, $sformatf("tB[%0d]", i));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            vec_t v;
            v = mk(($urandom_range(0, 9) == 0), 8'($urandom), ($urandom_range(0, 3) != 0),
                   1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
            step(v, 1'b0, $sformatf("rnd[%0d]", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
